// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared pipeline state encoding and drain-length default
package pipeline_stall_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;
  localparam int DRAIN_CYCLES_DEF = 4;
endpackage

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: per-stage pipeline controls from stall/branch plus run/step/halt sequencing
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic             i_halt_id,
  input  logic             i_dbg_run,
  input  logic             i_dbg_step,
  input  logic             i_dbg_pause,
  input  logic             i_dbg_clear,
  output logic             o_pipe_en,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_halted,
  output logic             o_wdog_err,
  output logic [CNT_W-1:0] o_stall_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int SW = $clog2(MAX_STALL + 1);
  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [SW-1:0]    consec_q, consec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wdog_q, wdog_d;
  logic             active, trip, halt_go;
  always_comb begin
    active         = state_q == S_RUN || state_q == S_STEP;
    trip           = active && i_stall && consec_q == SW'(MAX_STALL - 1);
    halt_go        = active && !i_stall && i_halt_id;
    o_pipe_en      = active || state_q == S_DRAIN;
    o_pc_write     = active && !i_stall && !i_halt_id;
    o_if_id_write  = active && !i_stall;
    o_if_id_flush  = (active && !i_stall && (i_halt_id || i_branch_taken)) || state_q == S_DRAIN;
    o_id_ex_bubble = active && i_stall;
    o_halted       = state_q == S_HALTED;
    o_wdog_err     = wdog_q;
    o_stall_count  = cnt_q;
    cnt_d          = (o_id_ex_bubble && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    consec_d       = active ? ((i_stall && !trip) ? consec_q + 1'b1 : '0) : consec_q;
    wdog_d         = wdog_q | trip;
    drain_d        = (state_q == S_DRAIN && drain_q != '0) ? drain_q - 1'b1 : drain_q;
    state_d        = state_q;
    case (state_q)
      S_IDLE:   state_d = i_dbg_run ? S_RUN : i_dbg_step ? S_STEP : S_IDLE;
      S_RUN, S_STEP: begin
        if (trip) state_d = S_HALTED;
        else if (halt_go) begin
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end
        else if (state_q == S_STEP || i_dbg_pause) state_d = S_IDLE;
      end
      S_DRAIN:  state_d = (drain_q == '0) ? S_HALTED : S_DRAIN;
      S_HALTED: if (i_dbg_clear) begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        wdog_d   = 1'b0;
        consec_d = '0;
      end
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      drain_q  <= '0;
      consec_q <= '0;
      cnt_q    <= '0;
      wdog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      consec_q <= consec_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vectors with hand-computed expectations
module tb_pipeline_stall_ctrl;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_stall = 0, i_branch_taken = 0, i_halt_id = 0;
  logic i_dbg_run = 0, i_dbg_step = 0, i_dbg_pause = 0, i_dbg_clear = 0;
  logic o_pipe_en, o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted, o_wdog_err;
  logic [15:0] o_stall_count;
  logic s_pipe_en, s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_halted, s_wdog_err;
  logic [3:0] s_stall_count;
  int n_vec = 0, n_err = 0;

  pipeline_stall_ctrl u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_halt_id(i_halt_id), .i_dbg_run(i_dbg_run), .i_dbg_step(i_dbg_step),
    .i_dbg_pause(i_dbg_pause), .i_dbg_clear(i_dbg_clear), .o_pipe_en(o_pipe_en),
    .o_pc_write(o_pc_write), .o_if_id_write(o_if_id_write), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_bubble(o_id_ex_bubble), .o_halted(o_halted), .o_wdog_err(o_wdog_err),
    .o_stall_count(o_stall_count)
  );

  pipeline_stall_ctrl #(.CNT_W(4)) u_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_halt_id(i_halt_id), .i_dbg_run(i_dbg_run), .i_dbg_step(i_dbg_step),
    .i_dbg_pause(i_dbg_pause), .i_dbg_clear(i_dbg_clear), .o_pipe_en(s_pipe_en),
    .o_pc_write(s_pc_write), .o_if_id_write(s_if_id_write), .o_if_id_flush(s_if_id_flush),
    .o_id_ex_bubble(s_id_ex_bubble), .o_halted(s_halted), .o_wdog_err(s_wdog_err),
    .o_stall_count(s_stall_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_pipe_en", o_pipe_en, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_wdog", o_wdog_err, 0);
    chk("rst_count", o_stall_count, 0);
    cyc();
    i_rst_n = 1;
    // stalls in RUN
    i_dbg_run = 1; #1;
    chk("idle_pipe_en", o_pipe_en, 0);
    cyc(); i_dbg_run = 0; i_stall = 1; #1;
    chk("st1_pipe_en", o_pipe_en, 1);
    chk("st1_pc_write", o_pc_write, 0);
    chk("st1_ifid_write", o_if_id_write, 0);
    chk("st1_bubble", o_id_ex_bubble, 1);
    cyc(); #1;
    chk("st2_bubble", o_id_ex_bubble, 1);
    chk("st2_pc_write", o_pc_write, 0);
    cyc(); i_stall = 0; #1;
    chk("st3_bubble", o_id_ex_bubble, 0);
    chk("st3_pc_write", o_pc_write, 1);
    chk("st3_count", o_stall_count, 2);
    // stall beats branch
    cyc(); i_stall = 1; i_branch_taken = 1; #1;
    chk("sb_flush", o_if_id_flush, 0);
    chk("sb_pc_write", o_pc_write, 0);
    cyc(); i_stall = 0; #1;
    chk("br_flush", o_if_id_flush, 1);
    chk("br_pc_write", o_pc_write, 1);
    chk("br_ifid_write", o_if_id_write, 1);
    chk("br_count", o_stall_count, 3);
    // halt and drain
    cyc(); i_branch_taken = 0; i_halt_id = 1; #1;
    chk("hlt_pc_write", o_pc_write, 0);
    chk("hlt_flush", o_if_id_flush, 1);
    cyc(); i_halt_id = 0;
    for (int i = 0; i < 4; i++) begin
      i_stall = (i == 1); i_dbg_run = (i == 2); #1;
      chk("drn_pipe_en", o_pipe_en, 1);
      chk("drn_pc_write", o_pc_write, 0);
      chk("drn_flush", o_if_id_flush, 1);
      chk("drn_bubble", o_id_ex_bubble, 0);
      chk("drn_halted", o_halted, 0);
      cyc();
    end
    i_stall = 0; i_dbg_run = 0; #1;
    chk("hlt_halted", o_halted, 1);
    chk("hlt_pipe_en", o_pipe_en, 0);
    chk("hlt_count", o_stall_count, 3);
    i_dbg_run = 1; cyc(); i_dbg_run = 0; #1;
    chk("hlt_ignore_run", o_halted, 1);
    i_dbg_clear = 1; cyc(); i_dbg_clear = 0; #1;
    chk("clr_halted", o_halted, 0);
    chk("clr_pipe_en", o_pipe_en, 0);
    chk("clr_count", o_stall_count, 0);
    // single step
    i_dbg_step = 1; #1;
    chk("stp_idle", o_pipe_en, 0);
    cyc(); i_dbg_step = 0; #1;
    chk("stp_pipe_en", o_pipe_en, 1);
    chk("stp_pc_write", o_pc_write, 1);
    cyc(); #1;
    chk("stp_after", o_pipe_en, 0);
    cyc(); #1;
    chk("stp_after2", o_pipe_en, 0);
    i_dbg_run = 1; i_dbg_step = 1; cyc(); i_dbg_run = 0; i_dbg_step = 0; #1;
    chk("rs_pipe_en", o_pipe_en, 1);
    cyc(); #1;
    chk("rs_still_run", o_pipe_en, 1);
    i_dbg_pause = 1; cyc(); i_dbg_pause = 0; #1;
    chk("pause_idle", o_pipe_en, 0);
    // watchdog
    i_dbg_run = 1; cyc(); i_dbg_run = 0; i_stall = 1;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("wd_bubble", o_id_ex_bubble, 1);
      chk("wd_err_pre", o_wdog_err, 0);
      cyc();
    end
    i_stall = 0; #1;
    chk("wd_err", o_wdog_err, 1);
    chk("wd_halted", o_halted, 1);
    chk("wd_pipe_en", o_pipe_en, 0);
    chk("wd_count", o_stall_count, 15);
    i_dbg_clear = 1; cyc(); i_dbg_clear = 0; #1;
    chk("wd_clr_err", o_wdog_err, 0);
    chk("wd_clr_count", o_stall_count, 0);
    // saturation: 20 non-consecutive stalls
    i_dbg_run = 1; cyc(); i_dbg_run = 0;
    for (int i = 0; i < 21; i++) begin
      i_stall = (i != 10);
      cyc();
    end
    i_stall = 0; #1;
    chk("sat_count16", o_stall_count, 20);
    chk("sat_count4", s_stall_count, 15);
    chk("sat_no_wdog", o_wdog_err, 0);
    chk("sat_running", o_pipe_en, 1);
    // async reset mid-drain
    i_halt_id = 1; cyc(); i_halt_id = 0; cyc(); #2;
    chk("ar_in_drain", o_if_id_flush, 1);
    i_rst_n = 0; #1;
    chk("ar_pipe_en", o_pipe_en, 0);
    chk("ar_flush", o_if_id_flush, 0);
    chk("ar_count", o_stall_count, 0);
    cyc();
    i_stall = 1; #1;
    chk("ar_hold_bubble", o_id_ex_bubble, 0);
    i_stall = 0; i_rst_n = 1; #1;
    chk("ar_idle", o_pipe_en, 0);
    i_dbg_run = 1; cyc(); i_dbg_run = 0; #1;
    chk("ar_rerun", o_pipe_en, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
